// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control carrier and hazard unit for a 5-stage in-order core.
// Carries decoded ID-stage controls through EX/MEM/WB, and generates the
// load-use stall, control-hazard flush and EX operand forwarding selects.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  // Decoded ID-stage controls
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       ALUSrcD,
  input  logic       BranchD,
  input  logic       JumpD,
  input  logic [1:0] ResultSrcD,
  input  logic [2:0] ALUControlD,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  // ALU status of the instruction currently in EX
  input  logic       ZeroE,
  // EX-stage controls
  output logic       ALUSrcE,
  output logic [2:0] ALUControlE,
  // MEM-stage controls
  output logic       MemWriteM,
  // WB-stage controls
  output logic       RegWriteW,
  output logic [1:0] ResultSrcW,
  output logic [4:0] RdW,
  // Hazard controls
  output logic       PCSrcE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  localparam logic [1:0] ResultMem = 2'b01;
  localparam logic [1:0] FwdReg    = 2'b00;
  localparam logic [1:0] FwdWb     = 2'b01;
  localparam logic [1:0] FwdMem    = 2'b10;

  // ID/EX stage register
  logic       reg_write_e_q;
  logic       mem_write_e_q;
  logic       alu_src_e_q;
  logic       branch_e_q;
  logic       jump_e_q;
  logic [1:0] result_src_e_q;
  logic [2:0] alu_control_e_q;
  logic [4:0] rs1_e_q;
  logic [4:0] rs2_e_q;
  logic [4:0] rd_e_q;

  // EX/MEM stage register
  logic       reg_write_m_q;
  logic       mem_write_m_q;
  logic [1:0] result_src_m_q;
  logic [4:0] rd_m_q;

  // MEM/WB stage register
  logic       reg_write_w_q;
  logic [1:0] result_src_w_q;
  logic [4:0] rd_w_q;

  // Hazard terms
  logic lw_stall;
  logic pc_src;
  logic flush_e;

  // Load-use and control hazard detection; x0 never counts as a dependency
  always_comb begin
    lw_stall = (result_src_e_q == ResultMem) && (rd_e_q != 5'd0) &&
               ((rd_e_q == Rs1D) || (rd_e_q == Rs2D));
    pc_src   = (branch_e_q && ZeroE) || jump_e_q;
    // Bubble EX on a load-use stall or when the instruction behind a redirect is squashed
    flush_e  = lw_stall || pc_src;
  end

  // ID/EX register: captures the decoded controls every edge, or a bubble on flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_e_q   <= 1'b0;
      mem_write_e_q   <= 1'b0;
      alu_src_e_q     <= 1'b0;
      branch_e_q      <= 1'b0;
      jump_e_q        <= 1'b0;
      result_src_e_q  <= 2'b00;
      alu_control_e_q <= 3'b000;
      rs1_e_q         <= 5'd0;
      rs2_e_q         <= 5'd0;
      rd_e_q          <= 5'd0;
    end else if (flush_e) begin
      reg_write_e_q   <= 1'b0;
      mem_write_e_q   <= 1'b0;
      alu_src_e_q     <= 1'b0;
      branch_e_q      <= 1'b0;
      jump_e_q        <= 1'b0;
      result_src_e_q  <= 2'b00;
      alu_control_e_q <= 3'b000;
      rs1_e_q         <= 5'd0;
      rs2_e_q         <= 5'd0;
      rd_e_q          <= 5'd0;
    end else begin
      reg_write_e_q   <= RegWriteD;
      mem_write_e_q   <= MemWriteD;
      alu_src_e_q     <= ALUSrcD;
      branch_e_q      <= BranchD;
      jump_e_q        <= JumpD;
      result_src_e_q  <= ResultSrcD;
      alu_control_e_q <= ALUControlD;
      rs1_e_q         <= Rs1D;
      rs2_e_q         <= Rs2D;
      rd_e_q          <= RdD;
    end
  end

  // EX/MEM register: free-running, never stalled or flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= 2'b00;
      rd_m_q         <= 5'd0;
    end else begin
      reg_write_m_q  <= reg_write_e_q;
      mem_write_m_q  <= mem_write_e_q;
      result_src_m_q <= result_src_e_q;
      rd_m_q         <= rd_e_q;
    end
  end

  // MEM/WB register: free-running, never stalled or flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
      rd_w_q         <= 5'd0;
    end else begin
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
      rd_w_q         <= rd_m_q;
    end
  end

  // Operand forwarding: the younger MEM result wins over WB when both match
  always_comb begin
    ForwardAE = FwdReg;
    if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == rs1_e_q)) begin
      ForwardAE = FwdMem;
    end else if (reg_write_w_q && (rd_w_q != 5'd0) && (rd_w_q == rs1_e_q)) begin
      ForwardAE = FwdWb;
    end

    ForwardBE = FwdReg;
    if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == rs2_e_q)) begin
      ForwardBE = FwdMem;
    end else if (reg_write_w_q && (rd_w_q != 5'd0) && (rd_w_q == rs2_e_q)) begin
      ForwardBE = FwdWb;
    end
  end

  // Output mapping; FlushD overrides StallD at the IF/ID register outside this block
  always_comb begin
    ALUSrcE     = alu_src_e_q;
    ALUControlE = alu_control_e_q;
    MemWriteM   = mem_write_m_q;
    RegWriteW   = reg_write_w_q;
    ResultSrcW  = result_src_w_q;
    RdW         = rd_w_q;
    PCSrcE      = pc_src;
    StallF      = lw_stall;
    StallD      = lw_stall;
    FlushD      = pc_src;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RegWriteD = 1'b0, MemWriteD = 1'b0, ALUSrcD = 1'b0, BranchD = 1'b0, JumpD = 1'b0;
  logic [1:0] ResultSrcD = 2'b00;
  logic [2:0] ALUControlD = 3'b000;
  logic [4:0] Rs1D = 5'd0, Rs2D = 5'd0, RdD = 5'd0;
  logic       ZeroE = 1'b0;
  logic       ALUSrcE, MemWriteM, RegWriteW, PCSrcE, StallF, StallD, FlushD;
  logic [2:0] ALUControlE;
  logic [1:0] ResultSrcW, ForwardAE, ForwardBE;
  logic [4:0] RdW;
  logic [20:0] all_out;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ZeroE(ZeroE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  always #5 clk = ~clk;

  assign all_out = {ALUSrcE, ALUControlE, MemWriteM, RegWriteW, ResultSrcW, RdW,
                    PCSrcE, StallF, StallD, FlushD, ForwardAE, ForwardBE};

  // Stimulus helpers (no checking inside)
  task automatic drive(input logic rw, input logic [1:0] rsrc, input logic mw,
                       input logic asrc, input logic br, input logic jp,
                       input logic [2:0] alu, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd);
    RegWriteD = rw; ResultSrcD = rsrc; MemWriteD = mw; ALUSrcD = asrc;
    BranchD = br; JumpD = jp; ALUControlD = alu; Rs1D = r1; Rs2D = r2; RdD = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pipe();
    drive(0, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0);
    ZeroE = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (all_out !== 21'd0) $display("FAIL reset_async got %h want 0", all_out); else n_pass++;
    repeat (2) step();
    n_checks++; if (all_out !== 21'd0) $display("FAIL reset_held got %h want 0", all_out); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    flush_pipe();
    drive(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd5);   // add x5
    step();
    drive(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd5, 5'd0, 5'd7);   // add x7, x5
    #1;
    n_checks++; if (StallD !== 1'b0) $display("FAIL b2b_nostall got %b want 0", StallD); else n_pass++;
    step();
    n_checks++; if (ForwardAE !== 2'b10) $display("FAIL b2b_fwd_mem got %b want 10", ForwardAE); else n_pass++;
    drive(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd5, 5'd0, 5'd8);   // add x8, x5
    step();
    n_checks++; if (ForwardAE !== 2'b01) $display("FAIL b2b_fwd_wb got %b want 01", ForwardAE); else n_pass++;
    n_checks++; if (ForwardBE !== 2'b00) $display("FAIL b2b_fwd_b got %b want 00", ForwardBE); else n_pass++;
    n_checks++; if ({RegWriteW, RdW} !== {1'b1, 5'd5}) $display("FAIL b2b_wb got %b/%0d want 1/5", RegWriteW, RdW); else n_pass++;
    // Both MEM and WB write x5: MEM must win
    flush_pipe();
    drive(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd5);
    step();
    drive(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd5);
    step();
    drive(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd3, 5'd5, 5'd9);
    step();
    n_checks++; if (ForwardBE !== 2'b10) $display("FAIL mem_priority got %b want 10", ForwardBE); else n_pass++;
  endtask

  task automatic test_load_use();
    flush_pipe();
    drive(1, 2'b01, 0, 1, 0, 0, 3'b000, 5'd2, 5'd0, 5'd6);   // lw x6
    step();
    drive(1, 2'b00, 0, 1, 0, 0, 3'b010, 5'd3, 5'd6, 5'd9);   // uses x6 as rs2
    #1;
    n_checks++; if ({StallF, StallD, FlushD} !== 3'b110) $display("FAIL lu_stall got %b want 110", {StallF, StallD, FlushD}); else n_pass++;
    step();   // IF/ID held, so the same D inputs remain
    n_checks++; if ({ALUSrcE, ALUControlE} !== 4'b0000) $display("FAIL lu_bubble got %b want 0000", {ALUSrcE, ALUControlE}); else n_pass++;
    n_checks++; if ({StallF, StallD} !== 2'b00) $display("FAIL lu_one_cycle got %b want 00", {StallF, StallD}); else n_pass++;
    step();
    n_checks++; if (ForwardBE !== 2'b01) $display("FAIL lu_fwd_wb got %b want 01", ForwardBE); else n_pass++;
    n_checks++; if ({ALUSrcE, ALUControlE} !== 4'b1010) $display("FAIL lu_issue got %b want 1010", {ALUSrcE, ALUControlE}); else n_pass++;
    n_checks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b01, 5'd6}) $display("FAIL lu_wb got %b want 1_01_00110", {RegWriteW, ResultSrcW, RdW}); else n_pass++;
  endtask

  task automatic test_branch();
    // Taken
    flush_pipe();
    drive(0, 2'b00, 0, 0, 1, 0, 3'b001, 5'd1, 5'd2, 5'd0);
    step();
    drive(1, 2'b00, 0, 1, 0, 0, 3'b011, 5'd3, 5'd4, 5'd10);
    ZeroE = 1'b1;
    #1;
    n_checks++; if ({PCSrcE, FlushD, StallD} !== 3'b110) $display("FAIL br_taken got %b want 110", {PCSrcE, FlushD, StallD}); else n_pass++;
    step();
    n_checks++; if ({ALUSrcE, ALUControlE, PCSrcE} !== 5'b00000) $display("FAIL br_bubble got %b want 00000", {ALUSrcE, ALUControlE, PCSrcE}); else n_pass++;
    // Not taken
    flush_pipe();
    drive(0, 2'b00, 0, 0, 1, 0, 3'b001, 5'd1, 5'd2, 5'd0);
    step();
    drive(1, 2'b00, 0, 1, 0, 0, 3'b011, 5'd3, 5'd4, 5'd10);
    ZeroE = 1'b0;
    #1;
    n_checks++; if ({PCSrcE, FlushD, StallD} !== 3'b000) $display("FAIL br_not_taken got %b want 000", {PCSrcE, FlushD, StallD}); else n_pass++;
    step();
    n_checks++; if ({ALUSrcE, ALUControlE} !== 4'b1011) $display("FAIL br_fallthru got %b want 1011", {ALUSrcE, ALUControlE}); else n_pass++;
    // Load-use and redirect in the same cycle
    flush_pipe();
    drive(1, 2'b01, 0, 0, 1, 0, 3'b001, 5'd1, 5'd2, 5'd4);
    step();
    drive(1, 2'b00, 0, 1, 0, 0, 3'b011, 5'd4, 5'd0, 5'd11);
    ZeroE = 1'b1;
    #1;
    n_checks++; if ({PCSrcE, StallF, StallD, FlushD} !== 4'b1111) $display("FAIL both_haz got %b want 1111", {PCSrcE, StallF, StallD, FlushD}); else n_pass++;
    step();
    n_checks++; if ({ALUSrcE, ALUControlE, PCSrcE} !== 5'b00000) $display("FAIL both_bubble got %b want 00000", {ALUSrcE, ALUControlE, PCSrcE}); else n_pass++;
    ZeroE = 1'b0;
  endtask

  task automatic test_jump();
    flush_pipe();
    drive(1, 2'b10, 0, 0, 0, 1, 3'b000, 5'd0, 5'd0, 5'd1);   // jal x1
    step();
    drive(0, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0);
    #1;
    n_checks++; if ({PCSrcE, FlushD} !== 2'b11) $display("FAIL jal_pcsrc got %b want 11", {PCSrcE, FlushD}); else n_pass++;
    step();
    step();
    n_checks++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b10, 5'd1}) $display("FAIL jal_wb got %b want 1_10_00001", {RegWriteW, ResultSrcW, RdW}); else n_pass++;
  endtask

  task automatic test_store();
    flush_pipe();
    drive(0, 2'b00, 1, 1, 0, 0, 3'b000, 5'd1, 5'd2, 5'd0);   // sw
    step();
    drive(0, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0);
    n_checks++; if (MemWriteM !== 1'b0) $display("FAIL sw_early got %b want 0", MemWriteM); else n_pass++;
    step();
    n_checks++; if (MemWriteM !== 1'b1) $display("FAIL sw_mem got %b want 1", MemWriteM); else n_pass++;
  endtask

  task automatic test_x0();
    flush_pipe();
    drive(1, 2'b01, 0, 0, 0, 0, 3'b000, 5'd1, 5'd2, 5'd0);   // lw x0
    step();
    drive(1, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd3);
    #1;
    n_checks++; if (StallD !== 1'b0) $display("FAIL x0_nostall got %b want 0", StallD); else n_pass++;
    step();
    n_checks++; if (ForwardAE !== 2'b00) $display("FAIL x0_fwd_mem got %b want 00", ForwardAE); else n_pass++;
    step();
    n_checks++; if (ForwardAE !== 2'b00) $display("FAIL x0_fwd_wb got %b want 00", ForwardAE); else n_pass++;
  endtask

  task automatic test_async_reset();
    flush_pipe();
    drive(1, 2'b01, 0, 0, 0, 0, 3'b000, 5'd2, 5'd0, 5'd6);   // lw x6
    step();
    drive(1, 2'b00, 0, 1, 0, 0, 3'b010, 5'd6, 5'd0, 5'd9);
    #1;
    n_checks++; if (StallD !== 1'b1) $display("FAIL ar_pre got %b want 1", StallD); else n_pass++;
    #2 reset = 1'b1;   // between edges
    #1;
    n_checks++; if (all_out !== 21'd0) $display("FAIL ar_immediate got %h want 0", all_out); else n_pass++;
    step();
    n_checks++; if (all_out !== 21'd0) $display("FAIL ar_held got %h want 0", all_out); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 2'b00, 0, 1, 0, 0, 3'b101, 5'd6, 5'd0, 5'd2);
    step();
    n_checks++; if ({ALUSrcE, ALUControlE, StallD} !== 5'b11010) $display("FAIL ar_first_edge got %b want 11010", {ALUSrcE, ALUControlE, StallD}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_jump();
    test_store();
    test_x0();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
